// File: rtl/aorb_pipe_if.sv
// Operand/result handshake bundle for aorb_pipe.
// master drives operands and out_ready; slave is the pipe itself.
interface aorb_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             f_any;
    logic [OW-1:0]    ones;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, f, f_any, ones, op_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, f, f_any, ones, op_count
    );
endinterface

// File: rtl/aorb_pipe.sv
// Registered bitwise-op stage (OR/AND/XOR/NOR) with a one-entry output register,
// optional sticky OR-accumulate, popcount/any status and a saturating transfer count.
module aorb_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    aorb_pipe_if.slave  bus
);
    localparam int OW = $clog2(WIDTH + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] f_next;
    logic [OW-1:0]    ones_next;

    assign bus.in_ready  = (state == EMPTY) | bus.out_ready;
    assign bus.out_valid = (state == FULL);
    assign accept        = bus.in_valid & bus.in_ready;
    assign deliver       = bus.out_valid & bus.out_ready;

    always_comb begin
        r = '0;
        case (bus.op)
            2'b00: r = bus.a | bus.b;
            2'b01: r = bus.a & bus.b;
            2'b10: r = bus.a ^ bus.b;
            2'b11: r = ~(bus.a | bus.b);
            default: r = '0;
        endcase
    end

    // A clear arriving with an accumulating operand wins: the fold restarts from r.
    assign acc_base = bus.acc_clr ? '0 : acc;
    assign f_next   = bus.acc_mode ? (acc_base | r) : r;

    always_comb begin
        ones_next = '0;
        for (int i = 0; i < WIDTH; i++)
            ones_next = ones_next + OW'(f_next[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            bus.f        <= '0;
            bus.f_any    <= 1'b0;
            bus.ones     <= '0;
            bus.op_count <= '0;
            acc          <= '0;
        end else begin
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (deliver && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (accept) begin
                bus.f     <= f_next;
                bus.f_any <= |f_next;
                bus.ones  <= ones_next;
                if (bus.op_count != {CNT_W{1'b1}})
                    bus.op_count <= bus.op_count + CNT_W'(1);
            end

            if (accept && bus.acc_mode)
                acc <= f_next;
            else if (bus.acc_clr)
                acc <= '0;
        end
    end
endmodule
